// File: rtl/instr_fetch_unit.sv
// Instruction-side front end: streams a program into local instruction memory,
// then holds the PC and fetches one instruction per cycle for the decoder.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        running,
  output logic        halted,
  output logic        fault
);

  localparam int          AW        = $clog2(IMEM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic [31:0]   imem [IMEM_DEPTH];

  logic          load_fire;
  logic          in_run;
  logic          out_of_range;
  logic          is_halt;
  logic [AW-1:0] idx;
  logic [31:0]   fetch_limit;
  logic [31:0]   pc4;
  logic [31:0]   jump_target;
  logic [31:0]   branch_target;

  // load_ready is gated by rst so it drops the instant reset asserts.
  assign load_ready = (state_q == ST_LOAD) && !rst;
  assign load_fire  = load_valid && load_ready;
  assign in_run     = (state_q == ST_RUN);

  assign idx          = pc_q[AW+1:2];
  assign fetch_limit  = {{(32-AW-3){1'b0}}, load_count_q, 2'b00};
  assign out_of_range = (pc_q >= fetch_limit);

  // Fetching past the loaded program yields 0, an R-type NOP, while FAULT is entered.
  assign instr   = (in_run && !out_of_range) ? imem[idx] : 32'h0;
  assign opcode  = instr[31:26];
  assign is_halt = (instr == HALT_WORD);

  assign pc4           = pc_q + 32'd4;
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  assign pc      = pc_q;
  assign running = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALT);
  assign fault   = (state_q == ST_FAULT);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          wr_ptr_d     = wr_ptr_q + AW'(1);
          load_count_d = load_count_q + (AW+1)'(1);
          if (load_last || (wr_ptr_q == LAST_ADDR)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_of_range)          state_d = ST_FAULT;
        else if (is_halt)          state_d = ST_HALT;
        else if (jump)             pc_d    = jump_target;
        else if (branch && zero)   pc_d    = branch_target;
        else                       pc_d    = pc4;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
    end
  end

  // NOTE: memory has no reset; load_count_q alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (load_fire) imem[wr_ptr_q] <= load_data;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural program/PC model pushes
// expected outputs each cycle, a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  localparam int M_LOAD  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;

  logic        lr_a, run_a, hlt_a, flt_a;
  logic [31:0] pc_a, instr_a;
  logic [5:0]  op_a;
  logic        lr_b, run_b, hlt_b, flt_b;
  logic [31:0] pc_b, instr_b;
  logic [5:0]  op_b;

  always #5 clk = ~clk;

  instr_fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_a),
    .load_data(load_data), .load_last(load_last), .jump(jump), .branch(branch),
    .zero(zero), .pc(pc_a), .instr(instr_a), .opcode(op_a),
    .running(run_a), .halted(hlt_a), .fault(flt_a)
  );

  instr_fetch_unit #(.IMEM_DEPTH(4), .RESET_PC(32'h0)) u_small (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_b),
    .load_data(load_data), .load_last(load_last), .jump(jump), .branch(branch),
    .zero(zero), .pc(pc_b), .instr(instr_b), .opcode(op_b),
    .running(run_b), .halted(hlt_b), .fault(flt_b)
  );

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        lr;
    logic        run;
    logic        hlt;
    logic        flt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  // Reference model: program image, word count, PC and mode.
  int          m_mode = M_LOAD;
  int          m_count = 0;
  int          m_depth = 64;
  bit          m_sel = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_mem [1024];
  logic [31:0] prog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare(input exp_t e);
    if (!e.sel) begin
      check("pc", pc_a, e.pc);
      check("instr", instr_a, e.instr);
      check("opcode", 32'(op_a), 32'(e.instr[31:26]));
      check("load_ready", 32'(lr_a), 32'(e.lr));
      check("running", 32'(run_a), 32'(e.run));
      check("halted", 32'(hlt_a), 32'(e.hlt));
      check("fault", 32'(flt_a), 32'(e.flt));
    end else begin
      check("small_pc", pc_b, e.pc);
      check("small_instr", instr_b, e.instr);
      check("small_load_ready", 32'(lr_b), 32'(e.lr));
      check("small_running", 32'(run_b), 32'(e.run));
      check("small_fault", 32'(flt_b), 32'(e.flt));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        compare(e);
      end
    end
  end

  function automatic exp_t expect_now(input logic [31:0] w);
    exp_t e;
    e.sel   = m_sel;
    e.pc    = m_pc;
    e.instr = w;
    e.lr    = (m_mode == M_LOAD) && !rst;
    e.run   = (m_mode == M_RUN);
    e.hlt   = (m_mode == M_HALT);
    e.flt   = (m_mode == M_FAULT);
    return e;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    load_valid = 1'b0; load_last = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
    m_mode = M_LOAD; m_pc = 32'h0; m_count = 0;
    sb_q.push_back(expect_now(32'h0));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus; the expectation covers the cycle these inputs are applied in.
  task automatic step(input logic lv, input logic [31:0] ld, input logic ll,
                      input logic j, input logic br, input logic z);
    logic [31:0] w;
    logic [31:0] pc4;
    bit          past_end;
    int          imm;
    @(posedge clk); #1;
    load_valid = lv; load_data = ld; load_last = ll;
    jump = j; branch = br; zero = z;
    past_end = (m_mode == M_RUN) && (m_pc >= 32'(m_count) * 32'd4);
    w = (m_mode == M_RUN && !past_end) ? m_mem[m_pc >> 2] : 32'h0;
    sb_q.push_back(expect_now(w));
    if (m_mode == M_LOAD) begin
      if (lv) begin
        m_mem[m_count] = ld;
        m_count++;
        if (ll || m_count == m_depth) m_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      pc4 = m_pc + 32'd4;
      imm = int'($signed(w[15:0]));
      if (past_end)                m_mode = M_FAULT;
      else if (w == 32'hFFFF_FFFF) m_mode = M_HALT;
      else if (j)                  m_pc = (pc4 & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
      else if (br && z)            m_pc = pc4 + 32'(imm * 4);
      else                         m_pc = pc4;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < prog.size(); i++)
      step(1'b1, prog[i], (i == prog.size() - 1), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic random_program();
    int len;
    int i;
    int s;
    len = $urandom_range(1, 12);
    prog = {};
    for (int k = 0; k < len; k++) begin
      s = int'($urandom_range(0, 12)) - 6;
      if ($urandom_range(0, 5) == 0) prog.push_back(32'hFFFF_FFFF);
      else prog.push_back({6'($urandom_range(0, 63)), 10'h0, 16'(s)});
    end
    i = 0;
    while (i < len) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b0, $urandom, 1'($urandom), 1'b0, 1'b0, 1'b0);
      end else begin
        step(1'b1, prog[i], (i == len - 1), 1'b0, 1'b0, 1'b0);
        i++;
      end
    end
    for (int c = 0; c < 30; c++)
      step(1'b0, 32'h0, 1'b0, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0), 1'($urandom));
  endtask

  initial begin : driver
    // Three-word program ending in halt.
    do_reset();
    prog = '{32'h2008_0005, 32'h2009_0007, 32'hFFFF_FFFF};
    load_all();
    idle(5);

    // Jump from address 4 to 0x40, which lies past the program and faults.
    do_reset();
    prog = '{32'h0000_0020, 32'h0800_0010, 32'h0000_0020};
    load_all();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Backward branch taken, then not taken, then halt.
    do_reset();
    prog = '{32'h0000_0020, 32'h0000_0020, 32'h1000_FFFE, 32'hFFFF_FFFF};
    load_all();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Two-word program running off its end.
    do_reset();
    prog = '{32'h0000_0020, 32'h0000_0020};
    load_all();
    idle(5);

    // Memory full on the depth-4 instance: six words offered, last never set.
    m_sel = 1'b1; m_depth = 4;
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 32'h0000_0020 + 32'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    m_sel = 1'b0; m_depth = 64;

    // Reset after two words; old words no longer count toward the program.
    do_reset();
    step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(1);
    prog = '{32'h0000_0020};
    load_all();
    idle(3);

    for (int p = 0; p < 20; p++) begin
      do_reset();
      random_program();
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
